mem_multicycle_param: RTL and testbench

- Parametrised single-port data/instruction memory with configurable data width, address width and read/write latency.
- Uses an explicit valid/ready request channel and a valid response channel, replacing fixed-latency enable/wr strobing.
- Sits between the cache/fetch controllers and the backing store. Lets the team sweep memory latency without RTL edits.

---
 rtl/mem_multicycle_param_if.sv | 25 ++
 rtl/mem_multicycle_param.sv | 150 +++++++++++++++
 tb/tb_mem_multicycle_param.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_multicycle_param_if.sv
// Request/response bus of mem_multicycle_param: a valid/ready request channel
// and a one-cycle valid response pulse carrying read data.
interface mem_multicycle_param_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_wr;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic                  resp_wr;
    logic [DATA_WIDTH-1:0] resp_rdata;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_wr, resp_rdata
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata,
        output req_ready, resp_valid, resp_wr, resp_rdata
    );
endinterface

// File: rtl/mem_multicycle_param.sv
// Single-port memory with configurable width, depth and read/write latency.
// Defining MEM_PIPELINED_EN swaps the blocking FSM for a fully pipelined response path.
module mem_multicycle_param #(
    parameter int    DATA_WIDTH = 16,
    parameter int    ADDR_WIDTH = 16,
    parameter int    RD_LATENCY = 4,
    parameter int    WR_LATENCY = 1,
    parameter string INIT_FILE  = ""
) (
    input  logic                   clk,
    input  logic                   rst,
    mem_multicycle_param_if.slave  bus
);
    localparam int OFF      = $clog2(DATA_WIDTH / 8);
    localparam int IDX_W    = ADDR_WIDTH - OFF;
    localparam int DEPTH    = 2 ** IDX_W;

    logic                  req_ready_q;
    logic                  accept;
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Gating with rst keeps a request seen during the first reset cycle out of the array.
    assign accept  = bus.req_valid & req_ready_q & ~rst;
    assign idx     = bus.req_addr[ADDR_WIDTH-1:OFF];
    assign rd_word = mem_q[idx];

    generate
        if (OFF > 0) begin : g_low_bits
            logic unused_low_bits;
            assign unused_low_bits = ^bus.req_addr[OFF-1:0];
        end
    endgenerate

    // NOTE: the array is deliberately left out of reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (accept && bus.req_wr) begin
            mem_q[idx] <= bus.req_wdata;
        end
    end

`ifdef MEM_PIPELINED_EN

    logic [RD_LATENCY-1:0] pipe_valid_q;
    logic [RD_LATENCY-1:0] pipe_wr_q;
    logic [DATA_WIDTH-1:0] pipe_data_q [RD_LATENCY];

    // Reads and writes share one depth, so responses leave in acceptance order.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_ready_q  <= 1'b0;
            pipe_valid_q <= '0;
            pipe_wr_q    <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_data_q[i] <= '0;
            end
        end else begin
            req_ready_q     <= 1'b1;
            pipe_valid_q[0] <= accept;
            pipe_wr_q[0]    <= accept & bus.req_wr;
            pipe_data_q[0]  <= (accept && !bus.req_wr) ? rd_word : '0;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_valid_q[i] <= pipe_valid_q[i-1];
                pipe_wr_q[i]    <= pipe_wr_q[i-1];
                pipe_data_q[i]  <= pipe_data_q[i-1];
            end
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = pipe_valid_q[RD_LATENCY-1];
    assign bus.resp_wr    = pipe_wr_q[RD_LATENCY-1];
    assign bus.resp_rdata = pipe_data_q[RD_LATENCY-1];

`else

    localparam int MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    typedef enum logic [0:0] {IDLE, BUSY} state_e;

    state_e                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      load_cnt;
    logic                  pend_wr_q;
    logic [DATA_WIDTH-1:0] pend_data_q;
    logic                  resp_valid_q;
    logic                  resp_wr_q;
    logic [DATA_WIDTH-1:0] resp_rdata_q;

    // cnt holds the edges still to pass before the response is presented; the
    // response is sampled by the requester on the edge LAT cycles after accept.
    assign load_cnt = bus.req_wr ? CNT_W'(WR_LATENCY - 1) : CNT_W'(RD_LATENCY - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            req_ready_q  <= 1'b0;
            pend_wr_q    <= 1'b0;
            pend_data_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_wr_q    <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            // NOTE: response registers default to idle so each pulse lasts exactly one cycle.
            resp_valid_q <= 1'b0;
            resp_wr_q    <= 1'b0;
            resp_rdata_q <= '0;
            case (state_q)
                IDLE: begin
                    req_ready_q <= 1'b1;
                    if (accept) begin
                        if (load_cnt == '0) begin
                            resp_valid_q <= 1'b1;
                            resp_wr_q    <= bus.req_wr;
                            resp_rdata_q <= bus.req_wr ? '0 : rd_word;
                        end else begin
                            state_q     <= BUSY;
                            cnt_q       <= load_cnt;
                            req_ready_q <= 1'b0;
                            pend_wr_q   <= bus.req_wr;
                            pend_data_q <= bus.req_wr ? '0 : rd_word;
                        end
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_q      <= IDLE;
                        req_ready_q  <= 1'b1;
                        resp_valid_q <= 1'b1;
                        resp_wr_q    <= pend_wr_q;
                        resp_rdata_q <= pend_data_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_wr    = resp_wr_q;
    assign bus.resp_rdata = resp_rdata_q;

`endif

endmodule

// File: tb/tb_mem_multicycle_param.sv
// Self-checking bench for mem_multicycle_param: vector table plus scoreboard,
// with hand-written reset, back-to-back and wide-word sequences.
`timescale 1ns/1ps
module tb_mem_multicycle_param;
    localparam int DW     = 16;
    localparam int AW     = 16;
    localparam int RD_LAT = 4;
    localparam int WR_LAT = 1;
`ifdef MEM_PIPELINED_EN
    localparam int W_LAT  = RD_LAT;
    localparam int RD_GAP = 1;
`else
    localparam int W_LAT  = WR_LAT;
    localparam int RD_GAP = RD_LAT;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_multicycle_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
    mem_multicycle_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) bus_w ();

    mem_multicycle_param #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(RD_LAT),
        .WR_LATENCY(WR_LAT), .INIT_FILE("")
    ) dut (.clk(clk), .rst(rst), .bus(bus));

    mem_multicycle_param #(
        .DATA_WIDTH(32), .ADDR_WIDTH(12), .RD_LATENCY(RD_LAT),
        .WR_LATENCY(WR_LAT), .INIT_FILE("")
    ) dut_w (.clk(clk), .rst(rst), .bus(bus_w));

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic          wr;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Response monitor: every response must match the oldest outstanding request.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (bus.resp_valid === 1'b1) begin
            check("resp_expected", sb.size() > 0, 1'b1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("resp_cycle", cyc, e.due);
                check("resp_wr", bus.resp_wr, e.wr);
                check("resp_rdata", bus.resp_rdata, e.data);
            end
        end else begin
            check("idle_rdata_zero", bus.resp_rdata, '0);
        end
    end

    // Holds the request until accepted; leaves req_valid high for the caller.
    task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic [DW-1:0] exp_rdata, output int acc, output int low);
        exp_t e;
        int   budget;
        budget = 0;
        low    = 0;
        acc    = -1;
        bus.req_valid = 1'b1;
        bus.req_wr    = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        while (bus.req_ready !== 1'b1 && budget < 50) begin
            low++;
            budget++;
            step();
        end
        if (budget >= 50) begin
            check("req_ready_timeout", bus.req_ready, 1'b1);
        end else begin
            acc    = cyc + 1;
            e.wr   = wr;
            e.data = wr ? '0 : exp_rdata;
            e.due  = acc + (wr ? W_LAT : RD_LAT) - 1;
            sb.push_back(e);
            step();
        end
    endtask

    task automatic release_req();
        bus.req_valid = 1'b0;
        bus.req_wr    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            n++;
            step();
        end
        check("drain_empty", sb.size(), 0);
    endtask

    task automatic wide_txn(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp_rdata, input int lat, input string tag);
        int n;
        n = 0;
        bus_w.req_valid = 1'b1;
        bus_w.req_wr    = wr;
        bus_w.req_addr  = addr;
        bus_w.req_wdata = wdata;
        while (bus_w.req_ready !== 1'b1 && n < 50) begin
            n++;
            step();
        end
        check({tag, "_ready"}, bus_w.req_ready, 1'b1);
        step();
        bus_w.req_valid = 1'b0;
        n = 0;
        while (bus_w.resp_valid !== 1'b1 && n < 50) begin
            n++;
            step();
        end
        check({tag, "_latency"}, n, lat - 1);
        check({tag, "_wr"}, bus_w.resp_wr, wr);
        check({tag, "_rdata"}, bus_w.resp_rdata, exp_rdata);
        step();
    endtask

    initial begin
        #500000;
        $fatal(1, "watchdog expired at cycle %0d", cyc);
    end

    initial begin
        vec_t vecs[14];
        int   acc;
        int   low;
        int   a1;
        int   a2;
        int   l2;
        logic [AW-1:0] rd_addr[5];
        logic [DW-1:0] rd_exp[5];

        vecs[0]  = '{1'b1, 16'h0010, 16'hBEEF, 16'h0000};
        vecs[1]  = '{1'b0, 16'h0010, 16'h0000, 16'hBEEF};
        vecs[2]  = '{1'b1, 16'h0010, 16'h1234, 16'h0000};
        vecs[3]  = '{1'b0, 16'h0011, 16'h0000, 16'h1234};
        vecs[4]  = '{1'b1, 16'h0000, 16'h1111, 16'h0000};
        vecs[5]  = '{1'b1, 16'h0002, 16'h2222, 16'h0000};
        vecs[6]  = '{1'b1, 16'hFFFE, 16'h7777, 16'h0000};
        vecs[7]  = '{1'b0, 16'hFFFF, 16'h0000, 16'h7777};
        vecs[8]  = '{1'b1, 16'h0020, 16'hA5A5, 16'h0000};
        vecs[9]  = '{1'b0, 16'h0020, 16'h0000, 16'hA5A5};
        vecs[10] = '{1'b0, 16'h0000, 16'h0000, 16'h1111};
        vecs[11] = '{1'b0, 16'h0002, 16'h0000, 16'h2222};
        vecs[12] = '{1'b1, 16'h0021, 16'h0F0F, 16'h0000};
        vecs[13] = '{1'b0, 16'h0020, 16'h0000, 16'h0F0F};

        rd_addr = '{16'h0010, 16'h0000, 16'h0002, 16'h0020, 16'hFFFE};
        rd_exp  = '{16'h1234, 16'h1111, 16'h2222, 16'h0F0F, 16'h7777};

        release_req();
        bus_w.req_valid = 1'b0;
        bus_w.req_wr    = 1'b0;
        bus_w.req_addr  = '0;
        bus_w.req_wdata = '0;

        // Reset state.
        step();
        step();
        check("rst_req_ready", bus.req_ready, 1'b0);
        check("rst_resp_valid", bus.resp_valid, 1'b0);
        check("rst_resp_wr", bus.resp_wr, 1'b0);
        check("rst_resp_rdata", bus.resp_rdata, '0);
        check("rst_wide_ready", bus_w.req_ready, 1'b0);
        rst = 1'b0;
        check("ready_before_first_edge", bus.req_ready, 1'b0);
        step();
        check("ready_after_release", bus.req_ready, 1'b1);

        // Vector table, issued back-to-back.
        for (int i = 0; i < 14; i++) begin
            issue(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, acc, low);
        end
        release_req();
        drain();

        // Two held reads: the second is accepted on the first one's response edge.
        issue(1'b0, 16'h0000, '0, 16'h1111, a1, low);
        issue(1'b0, 16'h0002, '0, 16'h2222, a2, l2);
        release_req();
        check("b2b_accept_gap", a2 - a1, RD_GAP);
        check("b2b_ready_low_cycles", l2, RD_GAP - 1);
        drain();

        // Five reads offered on consecutive cycles.
        for (int i = 0; i < 5; i++) begin
            issue(1'b0, rd_addr[i], '0, rd_exp[i], acc, low);
        end
        release_req();
        drain();

        // Reset two cycles after a read accept: that read never responds.
        issue(1'b1, 16'h0030, 16'h5A5A, '0, acc, low);
        issue(1'b0, 16'h0010, '0, 16'h1234, a1, low);
        release_req();
        step();
        rst = 1'b1;
        sb.delete();
        step();
        check("midrst_req_ready", bus.req_ready, 1'b0);
        check("midrst_resp_valid", bus.resp_valid, 1'b0);
        step();
        check("midrst_resp_valid_late", bus.resp_valid, 1'b0);
        rst = 1'b0;
        step();
        check("midrst_ready_after_release", bus.req_ready, 1'b1);
        for (int i = 0; i < 6; i++) step();
        issue(1'b0, 16'h0030, '0, 16'h5A5A, acc, low);
        issue(1'b0, 16'h0010, '0, 16'h1234, acc, low);
        release_req();
        drain();

        // 32-bit word instance: two low address bits are ignored.
        wide_txn(1'b1, 12'h004, 32'hDEADBEEF, 32'h0, W_LAT, "w32_wr");
        wide_txn(1'b0, 12'h006, 32'h0, 32'hDEADBEEF, RD_LAT, "w32_rd");
        wide_txn(1'b1, 12'h00B, 32'hCAFEF00D, 32'h0, W_LAT, "w32_wr2");
        wide_txn(1'b0, 12'h008, 32'h0, 32'hCAFEF00D, RD_LAT, "w32_rd2");
        wide_txn(1'b0, 12'h005, 32'h0, 32'hDEADBEEF, RD_LAT, "w32_rd3");

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
